mantissa_div_seq: RTL and testbench

Sequential mantissa divider. It is the inverse-direction companion of the mantissa multiplier in the same floating-point datapath. It takes two normalised mantissas (fraction bits only, hidden 1 implied) and returns the normalised quotient fraction plus a normalisation shift. It uses one restoring-division iteration per clock. Valid/ready handshakes on both sides let it sit between the exponent/sign unpack stage and the exponent-adjust/pack stage.

---
 rtl/mantissa_div_seq.sv | 131 +++++++++++++
 tb/tb_mantissa_div_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mantissa_div_seq.sv
// rtl/mantissa_div_seq.sv - sequential restoring divider for normalised mantissas
// One quotient bit per clock; valid/ready on both the operand and the result side.
module mantissa_div_seq #(
    parameter int BASELINE       = 15,
    parameter int MANTISSA_WIDTH = 15,
    parameter int CNT_W          = 5
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [BASELINE-1:BASELINE-MANTISSA_WIDTH]  Mantissa_X,
    input  logic [BASELINE-1:BASELINE-MANTISSA_WIDTH]  Mantissa_Y,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [BASELINE-1:BASELINE-MANTISSA_WIDTH]  Mantissa_Out,
    output logic                                       Shift,
    output logic                                       Inexact
);

    localparam int W = MANTISSA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ITER,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [W:0]       r_a;
    logic [W:0]       r_b;
    logic [W+1:0]     r_rem;
    logic [W-1:0]     r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_shift_n;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [W-1:0]     r_mant_out;
    logic             r_shift;
    logic             r_inexact;

    logic [W+1:0]     w_b_ext;
    logic             w_bit;
    logic [W+1:0]     w_diff;
    logic [W+1:0]     w_rem_next;
    logic [W-1:0]     w_q_next;
    logic             w_last;

    // R stays below 2B, so the difference never needs bit W+1 and the shift drops nothing.
    // The hidden quotient bit falls off the top of the W-bit shift register.
    always_comb begin
        w_b_ext    = {1'b0, r_b};
        w_bit      = (r_rem >= w_b_ext);
        w_diff     = w_bit ? (r_rem - w_b_ext) : r_rem;
        w_rem_next = w_diff << 1;
        w_q_next   = {r_q[W-2:0], w_bit};
        w_last     = (r_cnt == CNT_W'(W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_shift_n   <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_mant_out  <= '0;
            r_shift     <= 1'b0;
            r_inexact   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_in_ready && in_valid) begin
                        r_a        <= {1'b1, Mantissa_X};
                        r_b        <= {1'b1, Mantissa_Y};
                        r_in_ready <= 1'b0;
                        r_state    <= S_NORM;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_NORM: begin
                    if (r_a >= r_b) begin
                        r_shift_n <= 1'b0;
                        r_rem     <= {1'b0, r_a};
                    end else begin
                        r_shift_n <= 1'b1;
                        r_rem     <= {r_a, 1'b0};
                    end
                    r_q     <= '0;
                    r_cnt   <= '0;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    r_q   <= w_q_next;
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_mant_out  <= w_q_next;
                        r_shift     <= r_shift_n;
                        r_inexact   <= |w_rem_next;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign Mantissa_Out = r_mant_out;
    assign Shift        = r_shift;
    assign Inexact      = r_inexact;

endmodule

// File: tb/tb_mantissa_div_seq.sv
// tb/tb_mantissa_div_seq.sv - directed and model-checked bench for mantissa_div_seq
module tb_mantissa_div_seq;

    localparam int W = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  mx = '0;
    logic [W-1:0]  my = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  mo;
    logic          shift;
    logic          inexact;

    int n_checks = 0;
    int n_pass   = 0;

    mantissa_div_seq #(
        .BASELINE(15),
        .MANTISSA_WIDTH(W),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .Mantissa_X(mx),
        .Mantissa_Y(my),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Mantissa_Out(mo),
        .Shift(shift),
        .Inexact(inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Returns {inexact, shift, fraction} from exact integer division.
    function automatic logic [W+1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y);
        longint a, b, n, q, r;
        logic   s;
        a = longint'(1 << W) + longint'(x);
        b = longint'(1 << W) + longint'(y);
        s = (a < b);
        n = a << (W + int'(s));
        q = n / b;
        r = n % b;
        return {(r != 0), s, q[W-1:0]};
    endfunction

    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        in_valid = 1'b1;
        mx = x;
        my = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mx = ~x;
        my = ~y;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] e_frac, input logic e_shift, input logic e_inex);
        bit ok;
        int lat;
        launch(x, y, ok);
        if (!ok) return;
        wait_done(lat);
        check({tag, "_latency"}, lat, 32'd17);
        if (lat < 0) return;
        @(negedge clk);
        check({tag, "_frac"}, 32'(mo), 32'(e_frac));
        check({tag, "_shift"}, 32'(shift), 32'(e_shift));
        check({tag, "_inexact"}, 32'(inexact), 32'(e_inex));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_post_hs"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    initial begin
        bit             ok;
        int             lat;
        logic [W-1:0]   rx, ry;
        logic [W+1:0]   g;

        repeat (2) @(negedge clk);
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_state", {26'd0, in_ready, out_valid, shift, inexact, 2'b00}, {26'd0, 4'b1000, 2'b00});
        check("idle_frac", 32'(mo), 32'd0);

        run_op("one_one",    15'h0000, 15'h0000, 15'h0000, 1'b0, 1'b0);
        run_op("1p5_one",    15'h4000, 15'h0000, 15'h4000, 1'b0, 1'b0);
        run_op("max_max",    15'h7FFF, 15'h7FFF, 15'h0000, 1'b0, 1'b0);
        run_op("one_1p5",    15'h0000, 15'h4000, 15'h2AAA, 1'b1, 1'b1);
        run_op("one_max",    15'h0000, 15'h7FFF, 15'h0000, 1'b1, 1'b1);
        run_op("max_one",    15'h7FFF, 15'h0000, 15'h7FFF, 1'b0, 1'b0);
        run_op("1p25_1p5",   15'h2000, 15'h4000, 15'h5555, 1'b1, 1'b1);

        // Backpressure: result held, in_ready low, new operand pulses ignored.
        launch(15'h0000, 15'h4000, ok);
        wait_done(lat);
        check("bp_latency", lat, 32'd17);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {14'd0, out_valid, in_ready, shift, inexact, 1'b0, mo},
                  {14'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 15'h2AAA});
            in_valid = 1'b1;
            mx = 15'h7FFF;
            my = 15'h0000;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release", {30'd0, out_valid, in_ready}, 32'b01);
        run_op("bp_next", 15'h2000, 15'h4000, 15'h5555, 1'b1, 1'b1);

        // Asynchronous reset in the middle of the iteration phase.
        launch(15'h4000, 15'h0000, ok);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_outputs", {14'd0, out_valid, in_ready, shift, inexact, 1'b0, mo}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_release", {30'd0, out_valid, in_ready}, 32'b01);
        run_op("arst_next", 15'h4000, 15'h0000, 15'h4000, 1'b0, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            rx = W'($urandom);
            ry = W'($urandom);
            g  = golden(rx, ry);
            run_op("rnd", rx, ry, g[W-1:0], g[W], g[W+1]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
